// File: rtl/fir3_mac_secuencial_if.sv
// fir3_mac_secuencial_if: start/done handshake, operand and result bundle for the 3-tap MAC filter
interface fir3_mac_secuencial_if #(parameter int N = 25);
  logic start;
  logic signed [2*N-1:0] fk, fk_1, fk_2, b0, b1, b2, yk;
  logic done, busy, ovf;
  modport master(output start, fk, fk_1, fk_2, b0, b1, b2, input yk, done, busy, ovf);
  modport slave(input start, fk, fk_1, fk_2, b0, b1, b2, output yk, done, busy, ovf);
endinterface

// File: rtl/fir3_mac_secuencial.sv
// fir3_mac_secuencial: 3-tap fixed-point FIR output through one shared multiplier, rescaled and saturated
module fir3_mac_secuencial #(parameter int N = 25, parameter int F = 20) (
  input logic clk,
  input logic reset,
  fir3_mac_secuencial_if.slave bus
);
  localparam int W = 2 * N;
  localparam int A = 4 * N + 2;
  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, OUT} state_t;
  state_t state, state_n;
  logic signed [W-1:0] x0, x1, x2, c0, c1, c2, x, c, yk;
  logic signed [2*W-1:0] prod;
  logic signed [A-1:0] acc, r;
  logic done, ovf, sat;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // sequencing and operand selection for the shared multiplier; the upper bits of the
  // rescaled sum must all equal the sign bit for the result to fit in W bits
  always_comb begin
    state_n = state == IDLE ? (bus.start ? MAC0 : IDLE) :
              state == MAC0 ? MAC1 :
              state == MAC1 ? MAC2 :
              state == MAC2 ? OUT : IDLE;
    x = state == MAC0 ? x0 : state == MAC1 ? x1 : x2;
    c = state == MAC0 ? c0 : state == MAC1 ? c1 : c2;
    prod = x * c;
    r = acc >>> F;
    sat = ~(&r[A-1:W-1]) & (|r[A-1:W-1]);
  end
  // operand latch, accumulation and saturated result register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      yk <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
      {x0, x1, x2, c0, c1, c2} <= '0;
    end else begin
      done <= state == OUT;
      if (state == IDLE && bus.start) begin
        {x0, x1, x2} <= {bus.fk, bus.fk_1, bus.fk_2};
        {c0, c1, c2} <= {bus.b0, bus.b1, bus.b2};
        acc <= '0;
      end else if (state == MAC0 || state == MAC1 || state == MAC2) begin
        acc <= acc + {{2{prod[2*W-1]}}, prod};
      end else if (state == OUT) begin
        yk <= sat ? (r[A-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : r[W-1:0];
        ovf <= sat;
      end
    end
  end
  assign bus.yk = yk;
  assign bus.done = done;
  assign bus.ovf = ovf;
  assign bus.busy = state != IDLE;
endmodule
